// File: rtl/ni_pkg.sv
// ni_pkg: shared types and helpers for the NI local-injection stage.
//   ni_state_e  : injection FSM states
//   DIR_*       : bit positions of the one-hot routing request
//   encode_1of4 : 2-bit symbol -> 1-of-4 rail pattern
//   route_xy    : dimension-ordered (X then Y) routing request; all-zero
//                 result means the packet is addressed to this node
package ni_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROUTE,
    SET,
    RST,
    EOF_SET,
    EOF_RST,
    DROP
  } ni_state_e;

  localparam int unsigned DIR_S = 0;
  localparam int unsigned DIR_W = 1;
  localparam int unsigned DIR_N = 2;
  localparam int unsigned DIR_E = 3;

  // Widest coordinate route_xy accepts; callers zero-extend into it.
  localparam int unsigned NI_CW = 16;

  function automatic logic [3:0] encode_1of4(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  function automatic logic [3:0] route_xy(input logic [NI_CW-1:0] dx,
                                          input logic [NI_CW-1:0] dy,
                                          input logic [NI_CW-1:0] mx,
                                          input logic [NI_CW-1:0] my);
    logic [3:0] r;
    r = '0;
    if (dx > mx)      r[DIR_S] = 1'b1;
    else if (dx < mx) r[DIR_N] = 1'b1;
    else if (dy < my) r[DIR_W] = 1'b1;
    else if (dy > my) r[DIR_E] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// ni_sync_fifo: FD-entry x W-bit synchronous FIFO, first-word fall-through
// (rd_data_o shows the head whenever empty_o is low).
//   clk_i, rst_i        : clock, synchronous active-high reset
//   wr_en_i, wr_data_i  : push request (ignored when full)
//   rd_en_i, rd_data_o  : pop request (ignored when empty), head data
//   full_o, empty_o     : status flags
module ni_sync_fifo #(
  parameter int unsigned W  = 9,
  parameter int unsigned FD = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = $clog2(FD);

  logic [W-1:0] mem_q [FD];
  logic [PW:0]  wr_ptr_q, rd_ptr_q;
  logic         push, pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ni_local_inject.sv
// ni_local_inject: NI injection stage for one virtual circuit of the local
// input port. Buffers core flits, issues the routing request for each
// packet and drives flits as 1-of-4 rails with a 4-phase RTZ handshake.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_last/in_valid/in_ready : core-side flit stream
//   my_x, my_y          : static local coordinates
//   do0..do3            : rail k of every sub-channel (registered)
//   do4                 : eof rail (registered)
//   doa                 : asynchronous ack, synchronised by two flops
//   deco                : one-hot request [0]S [1]W [2]N [3]E
//   drop                : one-cycle pulse when a self-addressed packet is discarded
//   err                 : sticky ack timeout flag
// Optional feature: define NI_ACK_TIMEOUT_EN to enable the ack-timeout
// counter and err flag; otherwise err is tied low.
module ni_local_inject
  import ni_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned SCN    = DW / 2,
  parameter int unsigned AW     = 4,
  parameter int unsigned FD     = 4,
  parameter int unsigned TO_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  in_data,
  input  logic           in_last,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [AW-1:0]  my_x,
  input  logic [AW-1:0]  my_y,
  output logic [SCN-1:0] do0,
  output logic [SCN-1:0] do1,
  output logic [SCN-1:0] do2,
  output logic [SCN-1:0] do3,
  output logic           do4,
  input  logic           doa,
  output logic [3:0]     deco,
  output logic           drop,
  output logic           err
);

  if ((DW % 2) != 0 || SCN != DW / 2 || 2 * AW > DW || AW > NI_CW ||
      FD < 2 || (FD & (FD - 1)) != 0 || TO_CYC == 0) begin : g_cfg_check
    $error("ni_local_inject: unsupported parameter set");
  end

  ni_state_e             state_q, state_d;
  logic [3:0][SCN-1:0]   rail_q, rail_d;
  logic                  eof_q, eof_d;
  logic [3:0]            deco_q, deco_d;
  logic                  drop_q, drop_d;
  logic                  last_q, last_d;
  logic                  ack_s1_q, ack_s_q;

  logic                  pop, fifo_full, fifo_empty;
  logic [DW:0]           head;
  logic [DW-1:0]         head_data;
  logic                  head_last;
  logic [SCN-1:0][3:0]   sym_oh;
  logic [3:0][SCN-1:0]   head_rails;
  logic [3:0]            hdr_route;

  ni_sync_fifo #(
    .W  (DW + 1),
    .FD (FD)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (in_valid),
    .wr_data_i ({in_last, in_data}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign head_data = head[DW-1:0];
  assign head_last = head[DW];

  assign hdr_route = route_xy(NI_CW'(head_data[2*AW-1:AW]), NI_CW'(head_data[AW-1:0]),
                              NI_CW'(my_x), NI_CW'(my_y));

  // Transpose per-sub-channel one-hot symbols into per-rail vectors.
  always_comb begin
    sym_oh     = '0;
    head_rails = '0;
    for (int unsigned j = 0; j < SCN; j++) begin
      sym_oh[j] = encode_1of4(head_data[2*j +: 2]);
    end
    for (int unsigned j = 0; j < SCN; j++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        head_rails[k][j] = sym_oh[j][k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rail_d  = rail_q;
    eof_d   = eof_q;
    deco_d  = deco_q;
    drop_d  = 1'b0;
    last_d  = last_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ROUTE;
      end
      ROUTE: begin
        deco_d  = hdr_route;
        state_d = (hdr_route == '0) ? DROP : SET;
      end
      // Self-addressed: discard flits as they arrive, through the last one.
      DROP: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_last) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      SET: begin
        if (ack_s_q) begin
          pop     = 1'b1;
          last_d  = head_last;
          rail_d  = '0;
          state_d = RST;
        end else begin
          rail_d = head_rails;
        end
      end
      RST: begin
        if (!ack_s_q) begin
          if (last_q)           state_d = EOF_SET;
          else if (!fifo_empty) state_d = SET;
        end
      end
      EOF_SET: begin
        if (ack_s_q) begin
          eof_d   = 1'b0;
          state_d = EOF_RST;
        end else begin
          eof_d = 1'b1;
        end
      end
      EOF_RST: begin
        if (!ack_s_q) begin
          deco_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rail_q   <= '0;
      eof_q    <= 1'b0;
      deco_q   <= '0;
      drop_q   <= 1'b0;
      last_q   <= 1'b0;
      ack_s1_q <= 1'b0;
      ack_s_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rail_q   <= rail_d;
      eof_q    <= eof_d;
      deco_q   <= deco_d;
      drop_q   <= drop_d;
      last_q   <= last_d;
      ack_s1_q <= doa;
      ack_s_q  <= ack_s1_q;
    end
  end

  assign do0  = rail_q[0];
  assign do1  = rail_q[1];
  assign do2  = rail_q[2];
  assign do3  = rail_q[3];
  assign do4  = eof_q;
  assign deco = deco_q;
  assign drop = drop_q;

`ifdef NI_ACK_TIMEOUT_EN
  localparam int unsigned TCW = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;

  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           err_q, err_d;
  logic           waiting;

  // Counts only while the far side owes an ack edge; RST with ack low and
  // an empty FIFO is waiting on the core, not the router.
  always_comb begin
    waiting  = ((state_q == SET || state_q == EOF_SET) && !ack_s_q) ||
               ((state_q == RST || state_q == EOF_RST) && ack_s_q);
    to_cnt_d = to_cnt_q;
    if (state_d != state_q)
      to_cnt_d = '0;
    else if (waiting && to_cnt_q != TCW'(TO_CYC))
      to_cnt_d = to_cnt_q + {{(TCW-1){1'b0}}, 1'b1};
    err_d = err_q || (to_cnt_d == TCW'(TO_CYC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
